iprec: RTL and testbench
========================

# iprec

Receive-side IPv4 header stage that sits directly upstream of the UDP receiver. It takes the 16-bit IP word stream produced by the Ethernet/MAC header clipper and validates the IPv4 header: version, fragmentation, protocol, destination address and header checksum. Accepted datagrams have their header and options stripped, and the UDP segment (UDP header plus payload) is forwarded on the `udpsof`/`udpeof`/`udpvalidin`/`udpdatain` interface. Any trailing Ethernet pad bytes are trimmed using the IP total length.

## Interface
Parameters:
- `BCASTEN`, 1: when 1, destination 255.255.255.255 is also accepted (needed for DHCP).

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ipsof`  in  1  first word of IP datagram; coincides with `ipvalidin`=1.
- `ipeof`  in  1  last word delivered by the MAC stage (may include pad).
- `ipvalidin`  in  1  `ipdatain` valid this cycle; gaps allowed.
- `ipdatain`  in  16  IP word, network byte order, [15:8] = first byte.
- `intipaddr`  in  32  this node's IPv4 address.
- `udpsof`  out  1  first forwarded UDP word.
- `udpeof`  out  1  last forwarded UDP word.
- `udpvalidin`  out  1  `udpdatain` valid.
- `udpdatain`  out  16  forwarded word.
- `srcipaddr`  out  32  source IP of the last accepted datagram; held until the next accept.
- `hdrdrop`  out  1  one-cycle pulse when a datagram is rejected.
- `truncerr`  out  1  one-cycle pulse when a datagram ends early.

## Operation
- States:
  - IDLE: wait for `ipsof`&`ipvalidin`.
  - HDR: words 0-9.
  - OPT: option words, (IHL-5)*2 of them.
  - PAY: forward payload.
  - DROP: discard until `ipeof`.
- Header word checks:
  - w0: [15:12]=4 and IHL=[11:8]≥5, else reject.
  - w1: total length L latched.
  - w3: MF bit [13]=1 or offset [12:0]≠0 → reject (no reassembly).
  - w4: protocol [7:0] must be 0x11.
  - w6-7: latched to a shadow source register.
  - w8-9: must equal `intipaddr`, or all-ones when `BCASTEN`=1.
- Checksum: 16-bit ones'-complement accumulation over all header and option words, with end-around carry folded each add (17-bit add, carry added back). Final value must be 0xFFFF.
- Decision is made on the last header/option word.
  - Any failure: pulse `hdrdrop`, go to DROP. DROP exits on `ipeof`, or on the `ipeof` word itself if that word was the deciding word.
  - Also reject if L < 4*IHL+8 (no room for UDP header).
- On accept: copy the shadow source to `srcipaddr`, load remaining = ceil((L−4*IHL)/2) words, enter PAY.
- PAY: each valid input word is forwarded and decrements remaining.
  - The first forwarded word has `udpsof`=1.
  - The word bringing remaining to 0 has `udpeof`=1; go to IDLE, ignoring further input until the next `ipsof`.
  - Odd byte length: the last word is forwarded whole; the low byte is don't-care.
- `ipeof` in PAY with remaining>1 (truncated):
  - Forward that word with `udpeof`=1 and pulse `truncerr`.
  - Return to IDLE.
- `ipeof` in HDR/OPT: pulse `hdrdrop`, go to IDLE.
- `ipsof` in any non-IDLE state: abort the current datagram and treat the word as w0 of a new header. Pulse `truncerr` if the abort happens in PAY. No `udpeof` is generated for the aborted datagram.

## Timing
- Reset values:
  - All outputs 0.
  - `srcipaddr`=0.
  - State IDLE; counters and accumulator 0.
- Latency: one register stage. A word accepted at edge n appears on `udpdatain` with `udpvalidin`=1 after edge n.
- `udpvalidin` mirrors input gaps; `udpdatain` holds its value when invalid.
- `udpsof` and `udpeof` are asserted only together with `udpvalidin`. Both are set on the same word when the UDP segment is one word (impossible when legal; still defined).
- `hdrdrop`/`truncerr` are single-cycle, registered, in the cycle after the deciding input word.
- Back-to-back datagrams: `ipsof` may arrive in the cycle right after the previous `udpeof` input word with no idle cycle.
- Asynchronous reset mid-datagram clears everything immediately. No `udpeof` is emitted.

## Test plan
- Valid datagram: IHL=5, L=0x0024, proto 0x11, dst=`intipaddr`, correct checksum, 8 UDP words. Expect 8 output words identical to input, `udpsof` on word 1, `udpeof` on word 8, latency 1, `srcipaddr` updated.
- Same frame with checksum corrupted (+1). Expect `hdrdrop` one pulse after w9 and no `udpvalidin`.
- L=0x001E (5 UDP words) followed by 18 pad words, then `ipeof`. Expect `udpeof` on UDP word 5 and no pad forwarded. Also cover L odd (0x001D): still 5 words forwarded.
- IHL=6 with one 32-bit option, plus a randomised `ipvalidin` gap pattern. Expect the option words stripped, payload correct, and gaps mirrored.
- Rejects:
  - protocol 0x06: `hdrdrop`.
  - MF=1: `hdrdrop`.
  - dst=255.255.255.255 with `BCASTEN`=1: accepted. With `BCASTEN`=0: `hdrdrop`.
- `ipeof` after 3 of 8 payload words: `udpeof` on word 3 plus `truncerr`. Then `ipsof` mid-PAY: `truncerr`, and the new datagram is parsed correctly. `reset` low mid-PAY: all outputs 0 immediately.

Source files
------------

// File: rtl/iprec.sv
// IPv4 receive header stage: validates the header of each datagram from the MAC
// clipper, strips header and options, and forwards the UDP segment with pad trimmed.
//
// Stream handshake: a word transfers on any rising clock edge where its valid is
// high (ipvalidin in, udpvalidin out); there is no backpressure, so gaps on the
// input are mirrored one cycle later on the output and udpdatain holds otherwise.
module iprec #(
    parameter bit BCASTEN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ipsof,
    input  logic        ipeof,
    input  logic        ipvalidin,
    input  logic [15:0] ipdatain,
    input  logic [31:0] intipaddr,
    output logic        udpsof,
    output logic        udpeof,
    output logic        udpvalidin,
    output logic [15:0] udpdatain,
    output logic [31:0] srcipaddr,
    output logic        hdrdrop,
    output logic        truncerr,
    output logic [2:0]  dbgstate
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        OPT  = 3'd2,
        PAY  = 3'd3,
        DROP = 3'd4
    } state_t;

    state_t       state, state_nx;
    logic [4:0]   wcnt;
    logic [3:0]   ihl;
    logic [15:0]  totlen;
    logic [15:0]  csum;
    logic [15:0]  remaining;
    logic [31:0]  shadow;
    logic         bad;
    logic         dsthi_own;
    logic         dsthi_bc;
    logic         first;

    logic         start;
    logic         inhdr;
    logic         lastw;
    logic         badnow;
    logic         fail;
    logic [16:0]  sum17;
    logic [15:0]  csum_nx;
    logic [15:0]  paybytes;
    logic [15:0]  paywords;

    assign dbgstate = state;

    always_comb begin
        start    = ipvalidin & ipsof;
        inhdr    = ipvalidin & ~ipsof & ((state == HDR) | (state == OPT));
        sum17    = {1'b0, csum} + {1'b0, ipdatain};
        csum_nx  = sum17[15:0] + {15'd0, sum17[16]};
        lastw    = (wcnt == ({ihl, 1'b0} - 5'd1));
        paybytes = totlen - {10'd0, ihl, 2'b00};
        paywords = {1'b0, paybytes[15:1]} + {15'd0, paybytes[0]};

        badnow = bad;
        case (wcnt)
            5'd3: if (ipdatain[13] || (ipdatain[12:0] != 13'd0)) badnow = 1'b1;
            5'd4: if (ipdatain[7:0] != 8'h11) badnow = 1'b1;
            5'd9: if (!((dsthi_own && (ipdatain == intipaddr[15:0])) ||
                        (BCASTEN && dsthi_bc && (ipdatain == 16'hffff))))
                      badnow = 1'b1;
            default: ;
        endcase
        // Checksum is only meaningful once the final header/option word is folded in.
        fail = badnow | (csum_nx != 16'hffff) |
               ({1'b0, totlen} < ({11'd0, ihl, 2'b00} + 17'd8));

        state_nx = state;
        if (start) begin
            state_nx = ipeof ? IDLE : HDR;
        end else if (ipvalidin) begin
            case (state)
                HDR, OPT: begin
                    if (ipeof)              state_nx = IDLE;
                    else if (lastw)         state_nx = fail ? DROP : PAY;
                    else if (wcnt >= 5'd9)  state_nx = OPT;
                end
                PAY:  if (ipeof || (remaining == 16'd1)) state_nx = IDLE;
                DROP: if (ipeof) state_nx = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wcnt       <= 5'd0;
            ihl        <= 4'd0;
            totlen     <= 16'd0;
            csum       <= 16'd0;
            remaining  <= 16'd0;
            shadow     <= 32'd0;
            bad        <= 1'b0;
            dsthi_own  <= 1'b0;
            dsthi_bc   <= 1'b0;
            first      <= 1'b0;
            udpsof     <= 1'b0;
            udpeof     <= 1'b0;
            udpvalidin <= 1'b0;
            udpdatain  <= 16'd0;
            srcipaddr  <= 32'd0;
            hdrdrop    <= 1'b0;
            truncerr   <= 1'b0;
        end else begin
            udpvalidin <= 1'b0;
            udpsof     <= 1'b0;
            udpeof     <= 1'b0;
            hdrdrop    <= 1'b0;
            truncerr   <= 1'b0;
            if (start) begin
                // A bogus IHL still counts as 5 so the header always reaches a decision.
                wcnt      <= 5'd1;
                csum      <= ipdatain;
                ihl       <= (ipdatain[11:8] < 4'd5) ? 4'd5 : ipdatain[11:8];
                bad       <= (ipdatain[15:12] != 4'd4) || (ipdatain[11:8] < 4'd5);
                totlen    <= 16'd0;
                dsthi_own <= 1'b0;
                dsthi_bc  <= 1'b0;
                if (state == PAY) truncerr <= 1'b1;
                if (ipeof)        hdrdrop  <= 1'b1;
            end else if (inhdr) begin
                wcnt <= wcnt + 5'd1;
                csum <= csum_nx;
                bad  <= badnow;
                case (wcnt)
                    5'd1: totlen        <= ipdatain;
                    5'd6: shadow[31:16] <= ipdatain;
                    5'd7: shadow[15:0]  <= ipdatain;
                    5'd8: begin
                        dsthi_own <= (ipdatain == intipaddr[31:16]);
                        dsthi_bc  <= (ipdatain == 16'hffff);
                    end
                    default: ;
                endcase
                if (ipeof) begin
                    hdrdrop <= 1'b1;
                end else if (lastw) begin
                    if (fail) begin
                        hdrdrop <= 1'b1;
                    end else begin
                        srcipaddr <= shadow;
                        remaining <= paywords;
                        first     <= 1'b1;
                    end
                end
            end else if (ipvalidin && (state == PAY)) begin
                udpvalidin <= 1'b1;
                udpdatain  <= ipdatain;
                udpsof     <= first;
                first      <= 1'b0;
                remaining  <= remaining - 16'd1;
                if (remaining == 16'd1) begin
                    udpeof <= 1'b1;
                end else if (ipeof) begin
                    udpeof   <= 1'b1;
                    truncerr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_iprec.sv
// Scoreboard bench for iprec: builds IPv4 frames with real checksums, predicts the
// forwarded UDP words and hdrdrop/truncerr pulses, and compares at the falling edge.
module tb_iprec;

    localparam logic [31:0] MYIP  = 32'hc0a8_0a02;
    localparam logic [31:0] SRC_A = 32'hc0a8_0a01;
    localparam logic [31:0] SRC_B = 32'h0a00_0007;
    localparam logic [31:0] SRC_C = 32'hac10_0203;

    logic        clock;
    logic        reset;
    logic        ipsof, ipeof, ipvalidin;
    logic [15:0] ipdatain;
    logic [31:0] intipaddr;
    logic        udpsof, udpeof, udpvalidin, hdrdrop, truncerr;
    logic [15:0] udpdatain;
    logic [31:0] srcipaddr;
    logic [2:0]  dbgstate;
    logic        nb_udpsof, nb_udpeof, nb_udpvalidin, nb_hdrdrop, nb_truncerr;
    logic [15:0] nb_udpdatain;
    logic [31:0] nb_srcipaddr;
    logic [2:0]  nb_dbgstate;

    iprec #(.BCASTEN(1'b1)) dut (
        .clock(clock), .reset(reset), .ipsof(ipsof), .ipeof(ipeof),
        .ipvalidin(ipvalidin), .ipdatain(ipdatain), .intipaddr(intipaddr),
        .udpsof(udpsof), .udpeof(udpeof), .udpvalidin(udpvalidin),
        .udpdatain(udpdatain), .srcipaddr(srcipaddr), .hdrdrop(hdrdrop),
        .truncerr(truncerr), .dbgstate(dbgstate)
    );

    iprec #(.BCASTEN(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .ipsof(ipsof), .ipeof(ipeof),
        .ipvalidin(ipvalidin), .ipdatain(ipdatain), .intipaddr(intipaddr),
        .udpsof(nb_udpsof), .udpeof(nb_udpeof), .udpvalidin(nb_udpvalidin),
        .udpdatain(nb_udpdatain), .srcipaddr(nb_srcipaddr), .hdrdrop(nb_hdrdrop),
        .truncerr(nb_truncerr), .dbgstate(nb_dbgstate)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // scoreboard: {sof, eof, data} plus the cycle it must appear in
    logic [17:0] exp_q[$];
    int          exp_cyc[$];
    logic [15:0] hold_exp = 16'd0;
    int cnt_drop = 0, cnt_trunc = 0, cnt_drop_nb = 0;
    int exp_drop = 0, exp_trunc = 0, exp_drop_nb = 0;
    int last_drop_cyc = -1, hdr_end_cyc = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (hdrdrop) begin
                cnt_drop++;
                last_drop_cyc = cyc;
            end
            if (truncerr)   cnt_trunc++;
            if (nb_hdrdrop) cnt_drop_nb++;
            if (udpvalidin) begin
                if (exp_q.size() == 0) begin
                    check("udp_extra", udpvalidin, 1'b0);
                end else begin
                    logic [17:0] e;
                    int c;
                    e = exp_q.pop_front();
                    c = exp_cyc.pop_front();
                    check("udp_word", {udpsof, udpeof, udpdatain}, e);
                    check("udp_latency", cyc, c);
                    hold_exp = e[15:0];
                end
            end else begin
                check("udp_hold", udpdatain, hold_exp);
                check("udp_flags_idle", {udpsof, udpeof}, 2'b00);
            end
        end
    end

    // driver
    logic [15:0] frm[$];
    int          hl;

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            ipvalidin = 1'b0;
            ipsof     = 1'b0;
            ipeof     = 1'b0;
            ipdatain  = 16'($urandom);
        end
    endtask

    task automatic build(input logic [3:0] ihl, input logic [15:0] len, input logic [7:0] proto,
                         input logic [15:0] w3, input logic [31:0] src, input logic [31:0] dst,
                         input int npay, input bit corrupt);
        logic [16:0] s;
        logic [15:0] acc;
        int          nopt;
        nopt = (int'(ihl) - 5) * 2;
        frm.delete();
        frm.push_back({4'h4, ihl, 8'h00});
        frm.push_back(len);
        frm.push_back(16'h1234);
        frm.push_back(w3);
        frm.push_back({8'h40, proto});
        frm.push_back(16'h0000);
        frm.push_back(src[31:16]);
        frm.push_back(src[15:0]);
        frm.push_back(dst[31:16]);
        frm.push_back(dst[15:0]);
        for (int k = 0; k < nopt; k++) frm.push_back(16'($urandom));
        acc = 16'd0;
        foreach (frm[k]) begin
            s   = {1'b0, acc} + {1'b0, frm[k]};
            acc = s[15:0] + {15'd0, s[16]};
        end
        frm[5] = corrupt ? (~acc + 16'd1) : ~acc;
        hl = frm.size();
        for (int k = 0; k < npay; k++) frm.push_back(16'($urandom));
    endtask

    task automatic send_frame(input int nsend, input bit give_eof, input bit accept,
                              input int nfwd, input int gap_pct);
        for (int i = 0; i < nsend; i++) begin
            if (i > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
            @(negedge clock);
            ipvalidin = 1'b1;
            ipsof     = (i == 0);
            ipeof     = give_eof && (i == nsend - 1);
            ipdatain  = frm[i];
            if (i == hl - 1) hdr_end_cyc = cyc + 1;
            if (accept && i >= hl && i < hl + nfwd) begin
                exp_q.push_back({(i == hl), (i == hl + nfwd - 1) || (give_eof && i == nsend - 1), frm[i]});
                exp_cyc.push_back(cyc + 1);
            end
        end
    endtask

    task automatic finish_frame(input string tag);
        idle(3);
        check({tag, "_drain"}, exp_q.size(), 0);
        check({tag, "_hdrdrop"}, cnt_drop, exp_drop);
        check({tag, "_truncerr"}, cnt_trunc, exp_trunc);
        check({tag, "_nb_hdrdrop"}, cnt_drop_nb, exp_drop_nb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ipsof = 1'b0; ipeof = 1'b0; ipvalidin = 1'b0;
        ipdatain = 16'd0; intipaddr = MYIP;
        repeat (3) @(negedge clock);
        check("reset_outs", {udpvalidin, udpsof, udpeof, udpdatain, srcipaddr, hdrdrop, truncerr}, 53'd0);
        check("reset_state", dbgstate, 3'd0);
        reset = 1'b1;
        idle(2);

        // valid frame, DF set, 8 UDP words
        build(4'd5, 16'h0024, 8'h11, 16'h4000, SRC_A, MYIP, 8, 1'b0);
        send_frame(18, 1'b1, 1'b1, 8, 0);
        finish_frame("valid");
        check("srcip_a", srcipaddr, SRC_A);

        // corrupted checksum
        build(4'd5, 16'h0024, 8'h11, 16'h4000, SRC_B, MYIP, 8, 1'b1);
        send_frame(18, 1'b1, 1'b0, 0, 0);
        exp_drop++; exp_drop_nb++;
        finish_frame("csum_bad");
        check("csum_drop_time", last_drop_cyc, hdr_end_cyc);
        check("srcip_hold", srcipaddr, SRC_A);

        // pad trimming, even and odd length
        build(4'd5, 16'h001e, 8'h11, 16'h0000, SRC_A, MYIP, 5 + 18, 1'b0);
        send_frame(10 + 23, 1'b1, 1'b1, 5, 0);
        finish_frame("pad_even");
        build(4'd5, 16'h001d, 8'h11, 16'h0000, SRC_A, MYIP, 5 + 2, 1'b0);
        send_frame(17, 1'b1, 1'b1, 5, 0);
        finish_frame("pad_odd");

        // one option word pair with random input gaps
        build(4'd6, 16'h0028, 8'h11, 16'h0000, SRC_A, MYIP, 8, 1'b0);
        send_frame(20, 1'b1, 1'b1, 8, 30);
        finish_frame("opt_gaps");

        // header rejects
        build(4'd5, 16'h0024, 8'h06, 16'h0000, SRC_B, MYIP, 8, 1'b0);
        send_frame(18, 1'b1, 1'b0, 0, 0);
        exp_drop++; exp_drop_nb++;
        finish_frame("proto_tcp");
        check("proto_drop_time", last_drop_cyc, hdr_end_cyc);
        build(4'd5, 16'h0024, 8'h11, 16'h2000, SRC_B, MYIP, 8, 1'b0);
        send_frame(18, 1'b1, 1'b0, 0, 0);
        exp_drop++; exp_drop_nb++;
        finish_frame("mf_set");
        build(4'd5, 16'h0024, 8'h11, 16'h0001, SRC_B, MYIP, 8, 1'b0);
        send_frame(18, 1'b1, 1'b0, 0, 0);
        exp_drop++; exp_drop_nb++;
        finish_frame("frag_off");
        build(4'd5, 16'h0024, 8'h11, 16'h0000, SRC_B, 32'hc0a8_0a03, 8, 1'b0);
        send_frame(18, 1'b1, 1'b0, 0, 0);
        exp_drop++; exp_drop_nb++;
        finish_frame("dst_other");

        // total length boundary: 27 bytes rejected, 28 bytes accepted
        build(4'd5, 16'h001b, 8'h11, 16'h0000, SRC_B, MYIP, 4, 1'b0);
        send_frame(14, 1'b1, 1'b0, 0, 0);
        exp_drop++; exp_drop_nb++;
        finish_frame("len_short");
        build(4'd5, 16'h001c, 8'h11, 16'h0000, SRC_A, MYIP, 4, 1'b0);
        send_frame(14, 1'b1, 1'b1, 4, 0);
        finish_frame("len_min");

        // broadcast destination: accepted only with BCASTEN=1
        build(4'd5, 16'h0024, 8'h11, 16'h0000, SRC_B, 32'hffff_ffff, 8, 1'b0);
        send_frame(18, 1'b1, 1'b1, 8, 0);
        exp_drop_nb++;
        finish_frame("bcast");
        check("srcip_b", srcipaddr, SRC_B);

        // truncated after 3 of 8 payload words
        build(4'd5, 16'h0024, 8'h11, 16'h0000, SRC_A, MYIP, 3, 1'b0);
        send_frame(13, 1'b1, 1'b1, 8, 0);
        exp_trunc++;
        finish_frame("trunc");

        // ipsof mid-payload, new datagram follows with no gap, then back-to-back valid
        build(4'd5, 16'h0024, 8'h11, 16'h0000, SRC_A, MYIP, 8, 1'b0);
        send_frame(14, 1'b0, 1'b1, 8, 0);
        build(4'd5, 16'h0024, 8'h11, 16'h0000, SRC_C, MYIP, 8, 1'b0);
        send_frame(18, 1'b1, 1'b1, 8, 0);
        build(4'd5, 16'h0022, 8'h11, 16'h0000, SRC_B, MYIP, 7, 1'b0);
        send_frame(17, 1'b1, 1'b1, 7, 0);
        exp_trunc++;
        finish_frame("abort_b2b");
        check("srcip_last", srcipaddr, SRC_B);

        // asynchronous reset while a payload word is on the output
        build(4'd5, 16'h0024, 8'h11, 16'h0000, SRC_C, MYIP, 8, 1'b0);
        send_frame(13, 1'b0, 1'b1, 8, 0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        ipvalidin = 1'b0; ipsof = 1'b0; ipeof = 1'b0;
        #1;
        check("reset_mid", {udpvalidin, udpsof, udpeof, udpdatain, srcipaddr, hdrdrop, truncerr}, 53'd0);
        check("reset_mid_state", dbgstate, 3'd0);
        void'(exp_q.pop_back());
        void'(exp_cyc.pop_back());
        hold_exp = 16'd0;
        @(negedge clock);
        reset = 1'b1;
        finish_frame("reset_mid");

        build(4'd5, 16'h0024, 8'h11, 16'h0000, SRC_A, MYIP, 8, 1'b0);
        send_frame(18, 1'b1, 1'b1, 8, 20);
        finish_frame("recover");
        check("srcip_recover", srcipaddr, SRC_A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
